multicycle_control: RTL

//   Main control FSM for the multicycle MIPS datapath. Sequences each instruction through

---
 rtl/mips_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_control_outdec.sv | 100 ++++++++++
 rtl/multicycle_control.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALUOp codes
// (also consumed by ALUControl), FSM state encodings and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD     = 3'b000;
  localparam logic [2:0] ALUOP_SUB     = 3'b001;
  localparam logic [2:0] ALUOP_RFORMAT = 3'b010;
  localparam logic [2:0] ALUOP_AND     = 3'b011;
  localparam logic [2:0] ALUOP_OR      = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12,
    S_JREG   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       zero_ext;
  } ctrl_t;

  // Opcodes the datapath can execute; anything else is flagged as illegal in DECODE.
  function automatic logic opcode_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_outdec.sv
// Control-word decode for the multicycle controller. Pure Moore decode of the
// state, except the FETCH IR/PC loads follow mem_ready and IMMEX picks the ALU
// operation from the opcode.
module multicycle_control_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  // Decode the current state into datapath controls; unlisted controls stay 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle the memory returns the word.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_RFORMAT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ANDI: begin
            ctrl.alu_op   = ALUOP_AND;
            ctrl.zero_ext = 1'b1;
          end
          OP_ORI: begin
            ctrl.alu_op   = ALUOP_OR;
            ctrl.zero_ext = 1'b1;
          end
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      S_IMMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_JREG: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_RS;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Holds the state register,
// the sticky illegal-opcode flag and the retired-instruction counter; the
// control word itself comes from multicycle_control_outdec.
//
//   state      | meaning
//   RESET  (0) | leaving reset, all controls low
//   FETCH  (1) | read instruction at PC, PC+4; waits for mem_ready
//   DECODE (2) | branch target into ALUOut, dispatch on opcode
//   MEMADR (3) | lw/sw effective address
//   MEMRD  (4) | data read; waits for mem_ready
//   MEMWB  (5) | lw writeback (retires)
//   MEMWR  (6) | data write; waits for mem_ready (retires)
//   EXEC   (7) | R-type ALU op; jr diverts to JREG
//   ALUWB  (8) | R-type writeback (retires)
//   BRANCH (9) | beq compare and conditional PC load (retires)
//   IMMEX (10) | addi/andi/ori ALU op
//   IMMWB (11) | immediate writeback (retires)
//   JUMP  (12) | j target into PC (retires)
//   JREG  (13) | rs into PC (retires)
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             jr,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             zero_ext,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  ctrl_t            ctrl;

  multicycle_control_outdec u_outdec (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Next-state, illegal flag and retire-count update.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_EXEC;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEX;
          OP_J:                      state_d = S_JUMP;
          default:                   state_d = S_FETCH;
        endcase
        if (!opcode_supported(opcode)) illegal_d = 1'b1;
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC:   state_d = jr ? S_JREG : S_ALUWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP, S_JREG: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default:  state_d = S_RESET;
    endcase
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, sticky illegal flag and counter; reset aborts any pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign zero_ext      = ctrl.zero_ext;
  assign illegal       = illegal_q;
  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule
